// File: rtl/spi_frame_uart_tx.sv
// Frame FIFO plus 8N1 UART serialiser for 16-bit SPI frames.
// Each frame leaves as [HEADER], frame[15:8], frame[7:0] with a sticky overflow flag for dropped frames.
module spi_frame_uart_tx #(
    parameter int          CLOCK_FREQ = 10000000,
    parameter int          BAUD_RATE  = 9600,
    parameter int          FIFO_DEPTH = 4,
    parameter int          HEADER_EN  = 1,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   frame_data,
    input  logic                          frame_valid,
    input  logic                          clr_overflow,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam int CW           = PW + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [1:0]    LAST_BYTE = (HEADER_EN != 0) ? 2'd2 : 2'd1;
    localparam logic [1:0]    SEL_OFS   = (HEADER_EN != 0) ? 2'd0 : 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [15:0]   shadow_q, shadow_d;

    logic          pop;
    logic          push;
    logic [1:0]    byte_sel;
    logic [7:0]    cur_byte;
    logic          baud_done;

    // A frame arriving on a full FIFO is still accepted when the head leaves in the same cycle.
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign push = frame_valid && ((count_q != DEPTH_C) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (frame_valid && !push) begin
                ovf_q <= 1'b1;
            end else if (clr_overflow) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= frame_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shadow_q <= shadow_d;
        end
    end

    assign baud_done = (baud_q == BAUD_LAST);
    assign byte_sel  = byte_q + SEL_OFS;

    always_comb begin
        cur_byte = shadow_q[7:0];
        case (byte_sel)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = shadow_q[15:8];
            default: cur_byte = shadow_q[7:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shadow_d = mem_q[rd_ptr_q];
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                byte_d  = '0;
                bit_d   = '0;
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // tx decodes straight from state so an async reset forces the line high at once.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = cur_byte[bit_q];
            default: tx = 1'b1;
        endcase
    end

    // busy spans the pop cycle and drops on the final cycle of the last stop bit, giving a frame-length window.
    assign busy = (state_q != S_IDLE) &&
                  !((state_q == S_STOP) && (byte_q == LAST_BYTE) && baud_done);

    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_spi_frame_uart_tx.sv
// Bench for spi_frame_uart_tx: default-rate instance for exact timing, fast instances for FIFO, overflow,
// reset and random traffic against a frame-timeline reference model.
module tb_spi_frame_uart_tx;

    localparam int CA  = 1041;
    localparam int CB  = 16;
    localparam int FLB = 3 * 10 * CB;

    logic clk, rst;
    logic [15:0] fd_a, fd_b, fd_c;
    logic fv_a, fv_b, fv_c, clr_a, clr_b, clr_c;
    logic tx_a, tx_b, tx_c, busy_a, busy_b, busy_c, ov_a, ov_b, ov_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 0;

    spi_frame_uart_tx u_a (
        .clk(clk), .rst(rst), .frame_data(fd_a), .frame_valid(fv_a), .clr_overflow(clr_a),
        .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a), .overflow(ov_a));

    spi_frame_uart_tx #(.CLOCK_FREQ(160), .BAUD_RATE(10)) u_b (
        .clk(clk), .rst(rst), .frame_data(fd_b), .frame_valid(fv_b), .clr_overflow(clr_b),
        .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b), .overflow(ov_b));

    spi_frame_uart_tx #(.CLOCK_FREQ(160), .BAUD_RATE(10), .HEADER_EN(0)) u_c (
        .clk(clk), .rst(rst), .frame_data(fd_c), .frame_valid(fv_c), .clr_overflow(clr_c),
        .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c), .overflow(ov_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Line level at bit position p (0..10*nbytes-1) of a frame made of the given bytes.
    function automatic logic wave(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int p);
        int b;
        logic [7:0] v;
        b = p % 10;
        v = (p / 10 == 0) ? b0 : ((p / 10 == 1) ? b1 : b2);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return v[b-1];
    endfunction

    // Reference for instance b: each popped frame owns a fixed window on the timeline.
    logic [15:0] m_q[$];
    logic [15:0] m_fr = '0;
    bit m_ov = 0;
    int m_pop = -100000;
    int m_free = 0;
    int m_sz;
    bit m_popf;
    bit m_acc;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_q.delete();
            m_ov = 0;
            m_pop = -100000;
            m_free = 0;
        end else begin
            m_sz = m_q.size();
            m_popf = (cyc >= m_free) && (m_sz > 0);
            if (m_popf) begin
                m_fr = m_q.pop_front();
                m_pop = cyc;
                m_free = cyc + 2 + FLB;
            end
            m_acc = fv_b && ((m_sz < 4) || m_popf);
            if (m_acc) m_q.push_back(fd_b);
            if (fv_b && !m_acc) m_ov = 1;
            else if (clr_b) m_ov = 0;
        end
    end

    function automatic logic exp_tx_b(input int k);
        if (k >= m_pop + 1 && k < m_pop + 1 + FLB)
            return wave(8'hA5, m_fr[15:8], m_fr[7:0], (k - m_pop - 1) / CB);
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("b_tx", tx_b, exp_tx_b(cyc));
            chk("b_busy", busy_b, (cyc >= m_pop) && (cyc < m_pop + FLB));
            chk("b_count", cnt_b, m_q.size());
            chk("b_overflow", ov_b, m_ov);
        end
    end

    function automatic logic txs(input int sel);
        return (sel != 0) ? tx_c : tx_b;
    endfunction

    task automatic rx_byte(input int sel, output logic [7:0] b, output bit ok);
        int t;
        ok = 0;
        b = '0;
        t = 0;
        while (txs(sel) !== 1'b0) begin
            if (t >= 3000) return;
            @(negedge clk);
            t++;
        end
        repeat (CB / 2) @(negedge clk);
        if (txs(sel) !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CB) @(negedge clk);
            b[i] = txs(sel);
        end
        repeat (CB) @(negedge clk);
        ok = (txs(sel) === 1'b1);
    endtask

    task automatic rx_chk(input int sel, input string name, input logic [7:0] exp);
        logic [7:0] b;
        bit ok;
        rx_byte(sel, b, ok);
        chk({name, "_framing"}, ok, 1'b1);
        chk(name, b, exp);
    endtask

    task automatic send(input int sel, input logic [15:0] f);
        @(negedge clk);
        if (sel != 0) begin fv_c = 1'b1; fd_c = f; end
        else begin fv_b = 1'b1; fd_b = f; end
        @(negedge clk);
        fv_b = 1'b0;
        fv_c = 1'b0;
    endtask

    task automatic wait_idle_b();
        int t;
        t = 0;
        while ((busy_b !== 1'b0 || cnt_b !== 3'd0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("b_idle_wait", t < 5000, 1'b1);
    endtask

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  b0, b1, b2;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #900000;
        errs++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        int n0, bad, bcnt, peak;
        logic [7:0] e0, e1, e2;

        vecs[0] = '{16'h0003, 8'hA5, 8'h00, 8'h03};
        vecs[1] = '{16'hABCD, 8'hA5, 8'hAB, 8'hCD};
        vecs[2] = '{16'h8001, 8'hA5, 8'h80, 8'h01};
        vecs[3] = '{16'hFFFF, 8'hA5, 8'hFF, 8'hFF};
        vecs[4] = '{16'h5A3C, 8'hA5, 8'h5A, 8'h3C};

        rst = 1'b1;
        {fv_a, fv_b, fv_c, clr_a, clr_b, clr_c} = '0;
        fd_a = '0; fd_b = '0; fd_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_a", tx_a, 1'b1);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_count_a", cnt_a, 3'd0);
        chk("rst_ovf_a", ov_a, 1'b0);
        chk("rst_tx_b", tx_b, 1'b1);
        chk("rst_busy_b", busy_b, 1'b0);
        chk("rst_count_b", cnt_b, 3'd0);
        chk("rst_ovf_b", ov_b, 1'b0);
        rst = 1'b0;
        chk_en = 1;

        // Default-rate frame: latency, every bit width and value, busy length.
        @(negedge clk);
        fv_a = 1'b1; fd_a = 16'h0003;
        @(negedge clk);
        fv_a = 1'b0; fd_a = 16'hDEAD;
        n0 = cyc;
        chk("a_busy_edgeN", busy_a, 1'b0);
        @(negedge clk);
        chk("a_busy_edgeN1", busy_a, 1'b1);
        chk("a_tx_edgeN1", tx_a, 1'b1);
        bcnt = busy_a ? 1 : 0;
        for (int p = 0; p < 30; p++) begin
            bad = 0;
            for (int j = 0; j < CA; j++) begin
                @(negedge clk);
                if (tx_a !== wave(8'hA5, 8'h00, 8'h03, p)) bad++;
                if (busy_a === 1'b1) bcnt++;
            end
            chk($sformatf("a_bit%0d_badcycles", p), bad, 0);
        end
        chk("a_busy_len", bcnt, 31230);
        chk("a_busy_after", busy_a, 1'b0);
        chk("a_tx_after", tx_a, 1'b1);
        chk("a_end_cycle", cyc - n0, 31231);

        // Directed frames on both fast instances, table driven.
        for (int v = 0; v < 5; v++) begin
            send(0, vecs[v].frame);
            rx_chk(0, $sformatf("b_vec%0d_byte0", v), vecs[v].b0);
            rx_chk(0, $sformatf("b_vec%0d_byte1", v), vecs[v].b1);
            rx_chk(0, $sformatf("b_vec%0d_byte2", v), vecs[v].b2);
            send(1, vecs[v].frame);
            rx_chk(1, $sformatf("c_vec%0d_byte0", v), vecs[v].b1);
            rx_chk(1, $sformatf("c_vec%0d_byte1", v), vecs[v].b2);
        end

        repeat (40) @(negedge clk);
        send(1, 16'hABCD);
        bcnt = 0;
        for (int j = 0; j < 1000; j++) begin
            @(negedge clk);
            if (busy_c === 1'b1) bcnt++;
        end
        chk("c_busy_len", bcnt, 20 * CB);

        // Six frames back to back, then clear racing a drop, then clear alone.
        wait_idle_b();
        peak = 0;
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    @(negedge clk);
                    if (cnt_b > peak) peak = cnt_b;
                    if (i == 6) begin
                        chk("b_ovf_after_drop", ov_b, 1'b1);
                        chk("b_count_full", cnt_b, 3'd4);
                    end
                    if (i == 7) chk("b_ovf_set_beats_clr", ov_b, 1'b1);
                    if (i == 8) chk("b_ovf_cleared", ov_b, 1'b0);
                    fv_b = (i < 7);
                    fd_b = 16'(i);
                    clr_b = (i == 6 || i == 7);
                end
                fv_b = 1'b0;
                clr_b = 1'b0;
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    rx_chk(0, $sformatf("b_burst%0d_hdr", k), 8'hA5);
                    rx_chk(0, $sformatf("b_burst%0d_hi", k), 8'h00);
                    rx_chk(0, $sformatf("b_burst%0d_lo", k), 8'(k));
                end
            end
        join
        chk("b_count_peak", peak, 4);

        // Reset in the middle of the second byte's data bits with a frame still queued.
        wait_idle_b();
        @(negedge clk);
        fv_b = 1'b1; fd_b = 16'h1234;
        @(negedge clk);
        fd_b = 16'h5678;
        @(negedge clk);
        fv_b = 1'b0;
        bad = 0;
        while (tx_b !== 1'b0 && bad < 100) begin
            @(negedge clk);
            bad++;
        end
        chk("b_fall_seen", bad < 100, 1'b1);
        repeat (13 * CB) @(negedge clk);
        chk("b_tx_low_before_rst", tx_b, 1'b0);
        chk("b_count_before_rst", cnt_b, 3'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("b_rst_tx_async", tx_b, 1'b1);
        chk("b_rst_count_async", cnt_b, 3'd0);
        chk("b_rst_busy_async", busy_b, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(0, 16'h000F);
        rx_chk(0, "b_post_rst_hdr", 8'hA5);
        rx_chk(0, "b_post_rst_hi", 8'h00);
        rx_chk(0, "b_post_rst_lo", 8'h0F);

        // Random traffic, including garbage on frame_data while frame_valid is low.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            fv_b = ($urandom_range(99) < 2);
            fd_b = 16'($urandom);
            clr_b = ($urandom_range(99) < 3);
        end
        fv_b = 1'b0;
        clr_b = 1'b0;
        wait_idle_b();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
